mul_unit: RTL

Iterative multi-cycle multiplier for the ARM datapath. It sits directly downstream of the instruction decoder and consumes its multiply ALU control codes: 3'b101 MUL, 3'b110 UMULL, 3'b111 SMULL. It produces a 64-bit product as two 32-bit halves for the register-file write-back of RdLo/RdHi, plus N/Z flags. The main FSM holds the multiply execute state until `Done` is high.

---
 rtl/mul_unit.sv | 89 ++++++++
 1 files changed

// File: rtl/mul_unit.sv
// mul_unit: iterative radix-2 shift-add multiplier for MUL/UMULL/SMULL.
// Produces a 2*WIDTH product as two halves plus N/Z flags, WIDTH+2 cycles after acceptance.
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic             N,
    output logic             Z
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [2:0] OP_MUL   = 3'b101;
    localparam logic [2:0] OP_UMULL = 3'b110;
    localparam logic [2:0] OP_SMULL = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t           state, state_nx;
    logic [2:0]       op;
    logic             neg;
    logic [WIDTH-1:0] mcand, mplier;
    logic [2*WIDTH-1:0] acc, fixed;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   sum;
    logic             accept, last, is_smull, is_mul;

    assign is_smull = ALUControl == OP_SMULL;
    assign accept   = Start && (state == IDLE || state == DONE) &&
                      (ALUControl == OP_MUL || ALUControl == OP_UMULL || is_smull);
    assign last     = cnt == CW'(WIDTH - 1);
    // carry out of the upper-half add becomes the new top bit after the shift
    assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};
    assign fixed    = neg ? -acc : acc;
    assign is_mul   = op == OP_MUL;
    assign Busy     = state == CALC || state == FIX;
    assign Done     = state == DONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = accept                 ? CALC :
                   (state == CALC && last) ? FIX  :
                   state == FIX            ? DONE :
                   state == DONE           ? IDLE : state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op       <= '0;
            neg      <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            ResultLo <= '0;
            ResultHi <= '0;
            N        <= 1'b0;
            Z        <= 1'b0;
        end else if (accept) begin
            op     <= ALUControl;
            neg    <= is_smull & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
            mcand  <= (is_smull && SrcA[WIDTH-1]) ? -SrcA : SrcA;
            mplier <= (is_smull && SrcB[WIDTH-1]) ? -SrcB : SrcB;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == CALC) begin
            acc    <= {sum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end else if (state == FIX) begin
            ResultLo <= fixed[WIDTH-1:0];
            ResultHi <= is_mul ? '0 : fixed[2*WIDTH-1:WIDTH];
            N        <= is_mul ? fixed[WIDTH-1] : fixed[2*WIDTH-1];
            Z        <= is_mul ? (fixed[WIDTH-1:0] == '0) : (fixed == '0);
        end
    end
endmodule
